// File: rtl/lattice_seq.sv
// Key conditioning (sync, debounce, rising-edge pulse) and the idle/auto/manual
// sequencer that walks a fixed five-entry colour/unable table for the matrix driver.
module lattice_seq #(
  parameter int DEB_CYC  = 20000,
  parameter int HOLD_CYC = 1000000,
  parameter int DEB_W    = 16,
  parameter int HOLD_W   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_next,
  input  logic       key_mode,
  input  logic       pause,
  output logic [1:0] color,
  output logic [2:0] unable,
  output logic [2:0] step,
  output logic       auto_mode,
  output logic       step_pulse
);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_AUTO, S_MANUAL} state_t;

  // Index 0 is key_next, index 1 is key_mode.
  logic [1:0]       w_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_db;
  logic [1:0]       r_db_d;
  logic [1:0]       r_press;
  logic [DEB_W-1:0] r_deb_cnt [2];

  state_t           r_state;
  logic [2:0]       r_step;
  logic [1:0]       r_color;
  logic [2:0]       r_unable;
  logic             r_auto;
  logic             r_pulse;
  logic [HOLD_W-1:0] r_dwell;

  logic             w_nxt_p;
  logic             w_mode_p;
  logic             w_expire;
  logic [2:0]       w_step_nxt;
  logic [4:0]       w_tbl_nxt;
  logic [4:0]       w_tbl_first;

  function automatic logic [4:0] tbl(input logic [2:0] idx);
    case (idx)
      3'd0:    tbl = {2'b01, 3'b010};
      3'd1:    tbl = {2'b10, 3'b010};
      3'd2:    tbl = {2'b01, 3'b110};
      3'd3:    tbl = {2'b11, 3'b111};
      3'd4:    tbl = {2'b01, 3'b011};
      default: tbl = {2'b01, 3'b010};
    endcase
  endfunction

  assign w_raw       = {key_mode, key_next};
  assign w_nxt_p     = r_press[0];
  assign w_mode_p    = r_press[1];
  assign w_expire    = !pause && (r_dwell == HOLD_LAST);
  assign w_step_nxt  = (r_step == 3'd4) ? 3'd0 : r_step + 3'd1;
  assign w_tbl_nxt   = tbl(w_step_nxt);
  assign w_tbl_first = tbl(3'd0);

  // Synchroniser -> debouncer -> registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      r_press <= '0;
      for (int k = 0; k < 2; k++) r_deb_cnt[k] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      r_press <= r_db & ~r_db_d;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_deb_cnt[k] <= '0;
        end else if (r_deb_cnt[k] == DEB_LAST) begin
          r_db[k]      <= r_sync2[k];
          r_deb_cnt[k] <= '0;
        end else begin
          r_deb_cnt[k] <= r_deb_cnt[k] + DEB_W'(1);
        end
      end
    end
  end

  // Sequencer; a key press and a dwell expiry in the same cycle merge into one advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_step   <= 3'd0;
      r_color  <= 2'b00;
      r_unable <= 3'b000;
      r_auto   <= 1'b0;
      r_pulse  <= 1'b0;
      r_dwell  <= '0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_nxt_p || w_mode_p) begin
            r_state             <= S_AUTO;
            r_auto              <= 1'b1;
            r_step              <= 3'd0;
            {r_color, r_unable} <= w_tbl_first;
            r_pulse             <= 1'b1;
            r_dwell             <= '0;
          end
        end
        S_AUTO: begin
          if (w_nxt_p || w_expire) begin
            r_step              <= w_step_nxt;
            {r_color, r_unable} <= w_tbl_nxt;
            r_pulse             <= 1'b1;
            r_dwell             <= '0;
          end else if (!pause) begin
            r_dwell <= r_dwell + HOLD_W'(1);
          end
          if (w_mode_p) begin
            r_state <= S_MANUAL;
            r_auto  <= 1'b0;
            r_dwell <= '0;
          end
        end
        S_MANUAL: begin
          r_dwell <= '0;
          if (w_nxt_p) begin
            r_step              <= w_step_nxt;
            {r_color, r_unable} <= w_tbl_nxt;
            r_pulse             <= 1'b1;
          end
          if (w_mode_p) begin
            r_state <= S_AUTO;
            r_auto  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_auto  <= 1'b0;
        end
      endcase
    end
  end

  assign color      = r_color;
  assign unable     = r_unable;
  assign step       = r_step;
  assign auto_mode  = r_auto;
  assign step_pulse = r_pulse;

endmodule
